// File: rtl/ysyx_23060096_alu_pkg.sv
// ysyx_23060096_alu_pkg: opcodes, flag bit positions and FSM encoding for the pipelined ALU.
package ysyx_23060096_alu_pkg;
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_NOT  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SEQ  = 4'd7;
  localparam logic [3:0] ALU_SLTU = 4'd8;
  localparam logic [3:0] ALU_SLL  = 4'd9;
  localparam logic [3:0] ALU_SRL  = 4'd10;
  localparam logic [3:0] ALU_SRA  = 4'd11;
  localparam logic [3:0] ALU_MUL  = 4'd12;
  localparam int FLG_ZERO  = 0;
  localparam int FLG_CARRY = 1;
  localparam int FLG_OVF   = 2;
  localparam int FLG_ILL   = 3;
  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_MUL_BUSY = 1'b1;
endpackage

// File: rtl/ysyx_23060096_alu_addsub.sv
// ysyx_23060096_alu_addsub: combinational add/sub; o_carry reads as borrow when subtracting.
module ysyx_23060096_alu_addsub #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sub,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry,
  output logic             o_ovf
);
  logic [WIDTH-1:0] w_b;
  logic [WIDTH:0]   w_ext;
  assign w_b     = i_sub ? ~i_b : i_b;
  assign w_ext   = {1'b0, i_a} + {1'b0, w_b} + {{WIDTH{1'b0}}, i_sub};
  assign o_sum   = w_ext[WIDTH-1:0];
  assign o_carry = w_ext[WIDTH] ^ i_sub;
  assign o_ovf   = (i_a[WIDTH-1] == w_b[WIDTH-1]) & (o_sum[WIDTH-1] != i_a[WIDTH-1]);
endmodule

// File: rtl/ysyx_23060096_alu_pipe.sv
// ysyx_23060096_alu_pipe: registered WIDTH-bit ALU with valid/ready on both sides.
// Define YSYX_23060096_ALU_MUL_EN to add the iterative shift-add multiplier on op 12.
module ysyx_23060096_alu_pipe
  import ysyx_23060096_alu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic [3:0]       out_flags
);
  logic             w_idle, w_acc, w_lt, w_carry, w_ovf, w_mul_start;
  logic [WIDTH-1:0] w_sum, w_res;
  logic [3:0]       w_flags;
  logic [SHW-1:0]   w_sh;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_res;
  logic [3:0]       r_flags;
  assign w_sh = in_b[SHW-1:0];
  ysyx_23060096_alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .i_a(in_a), .i_b(in_b), .i_sub(in_op != ALU_ADD),
    .o_sum(w_sum), .o_carry(w_carry), .o_ovf(w_ovf)
  );
  assign w_lt = w_sum[WIDTH-1] ^ w_ovf;
  always_comb begin
    w_res   = '0;
    w_flags = '0;
    case (in_op)
      ALU_ADD, ALU_SUB: begin
        w_res            = w_sum;
        w_flags[FLG_CARRY] = w_carry;
        w_flags[FLG_OVF]   = w_ovf;
      end
      ALU_NOT:  w_res = ~in_a;
      ALU_AND:  w_res = in_a & in_b;
      ALU_OR:   w_res = in_a | in_b;
      ALU_XOR:  w_res = in_a ^ in_b;
      ALU_SLT:  w_res = {{(WIDTH-1){1'b0}}, w_lt};
      ALU_SEQ:  w_res = {{(WIDTH-1){1'b0}}, in_a == in_b};
      ALU_SLTU: w_res = {{(WIDTH-1){1'b0}}, w_carry};
      ALU_SLL:  w_res = in_a << w_sh;
      ALU_SRL:  w_res = in_a >> w_sh;
      ALU_SRA:  w_res = WIDTH'($signed(in_a) >>> w_sh);
`ifdef YSYX_23060096_ALU_MUL_EN
      ALU_MUL:  w_res = '0;
`endif
      default:  w_flags[FLG_ILL] = 1'b1;
    endcase
    w_flags[FLG_ZERO] = (w_res == '0);
  end
  assign in_ready = w_idle & (!r_out_valid | out_ready);
  assign w_acc    = in_valid & in_ready;
`ifdef YSYX_23060096_ALU_MUL_EN
  logic             r_state;
  logic [WIDTH-1:0] r_mcand, r_mplier, r_acc;
  logic [SHW-1:0]   r_cnt;
  logic [WIDTH-1:0] w_mul_nxt;
  logic             w_mul_done;
  assign w_idle      = (r_state == ST_IDLE);
  assign w_mul_start = w_acc & (in_op == ALU_MUL);
  assign w_mul_done  = (r_state == ST_MUL_BUSY) & (r_cnt == SHW'(WIDTH-1));
  assign w_mul_nxt   = r_acc + (r_mplier[0] ? r_mcand : '0);
  // one partial product per cycle; the last step feeds the result register directly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (r_state == ST_IDLE) begin
      if (w_mul_start) begin
        r_state  <= ST_MUL_BUSY;
        r_mcand  <= in_a;
        r_mplier <= in_b;
        r_acc    <= '0;
        r_cnt    <= '0;
      end
    end else begin
      r_acc    <= w_mul_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 1'b1;
      if (w_mul_done) r_state <= ST_IDLE;
    end
  end
`else
  assign w_idle      = 1'b1;
  assign w_mul_start = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_res       <= '0;
      r_flags     <= '0;
    end else begin
      if (w_acc) begin
        r_out_valid <= !w_mul_start;
        r_res       <= w_res;
        r_flags     <= w_flags;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
`ifdef YSYX_23060096_ALU_MUL_EN
      if (w_mul_done) begin
        r_out_valid <= 1'b1;
        r_res       <= w_mul_nxt;
        r_flags     <= {3'b000, w_mul_nxt == '0};
      end
`endif
    end
  end
  assign out_valid = r_out_valid;
  assign out_res   = r_res;
  assign out_flags = r_flags;
endmodule

// File: doc/ysyx_23060096_alu_pipe.md
Name: ysyx_23060096_alu_pipe

Overview:
Parametrised, registered integer ALU with a valid/ready handshake on both the operand and result sides. Generalises the team's 4-bit combinational ALU to WIDTH bits. Adds signed/unsigned compares, shifts and a status-flag output. Sits between the decode/operand-fetch stage and writeback in the npc datapath.

Parameters:
WIDTH, 32, operand/result width in bits (>= 4, power of two)
SHW, $clog2(WIDTH), shift-amount width (derived; not overridden)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operands/op presented
in_ready  out  1  block accepts operands this cycle
in_a  in  WIDTH  operand A
in_b  in  WIDTH  operand B
in_op  in  4  operation code (see package)
out_valid  out  1  result register holds a valid result
out_ready  in  1  consumer accepts result this cycle
out_res  out  WIDTH  result
out_flags  out  4  {illegal, overflow, carry, zero}

Behaviour:
- Reset, asynchronous, while rst_n=0: out_valid=0, out_res=0, out_flags=0, state=IDLE; in_ready=1 one cycle after deassertion. Reset mid-operation discards all in-flight work.
- Handshake: transfer on in_valid&in_ready; result leaves on out_valid&out_ready. in_ready = (state==IDLE) & (!out_valid | out_ready) — full throughput, no bubble on back-to-back ops.
- Single-cycle ops: result and flags registered on the accept edge; out_valid rises next cycle (latency 1).
- Stall: out_valid=1 & out_ready=0 holds out_res/out_flags stable; in_ready=0.
- Opcodes: 0 ADD, 1 SUB, 2 NOT A, 3 AND, 4 OR, 5 XOR, 6 SLT signed (res=1/0), 7 SEQ (res=1 if A==B), 8 SLTU, 9 SLL, 10 SRL, 11 SRA (shift amount = in_b[SHW-1:0], upper bits ignored), 12 MUL (optional), 13-15 reserved.
- Arithmetic: ADD/SUB computed in WIDTH+1 bits; SUB = A + ~B + 1. carry = bit WIDTH for ADD; for SUB, carry=1 means borrow (A<B unsigned). overflow = signed overflow for ADD/SUB only, else 0. carry=0 for non-ADD/SUB ops. zero = (out_res==0) for every op.
- Illegal/reserved op: accepted normally, out_res=0, illegal=1, zero=1, other flags 0.
- States: IDLE, MUL_BUSY (only with optional feature). Without the feature the FSM is permanently IDLE.

Optional Feature:
YSYX_23060096_ALU_MUL_EN
- Defined: op 12 = iterative shift-add multiply, low WIDTH bits of A*B (same for signed/unsigned). On accept, go IDLE->MUL_BUSY; in_ready=0; one partial-product step per cycle for WIDTH cycles. Then load result, return to IDLE, out_valid=1. Latency WIDTH+1 from accept to out_valid. Flags: zero only, carry/overflow=0. out_ready ignored while busy, but the accept condition guarantees the output register is free. Reset during MUL_BUSY aborts to IDLE.
- Undefined: op 12 behaves as a reserved op (illegal=1, res=0); no multiplier registers synthesised.

Decomposition:
- Package ysyx_23060096_alu_pkg holds: opcode localparams (ALU_ADD..ALU_MUL), flag bit indices (FLG_ZERO=0, FLG_CARRY=1, FLG_OVF=2, FLG_ILL=3), FSM state encoding.
- One sub-module ysyx_23060096_alu_addsub: combinational WIDTH-bit add/sub producing sum, carry, overflow. Shared by ADD, SUB, SLT and SLTU.
- Multiplier datapath stays inline under the macro.

Test Plan:
- Reset: hold rst_n=0 mid-stream with in_valid=1 -> out_valid=0, out_res=0, flags=0. One cycle after release, in_ready=1.
- ADD, WIDTH=32: A=0xFFFFFFFF, B=1 -> res=0, carry=1, zero=1, overflow=0. Then A=0x7FFFFFFF, B=1 -> res=0x80000000, overflow=1, carry=0.
- SUB/SLT: A=3, B=5 SUB -> res=0xFFFFFFFE, carry(borrow)=1. SLT A=0xFFFFFFFF(-1), B=1 -> res=1. SLTU same operands -> res=0.
- Shifts: SRA A=0x80000000, B=0x21 (amount 1) -> 0xC0000000. SRL same -> 0x40000000. SLL A=1, B=31 -> 0x80000000.
- Back-pressure: 4 back-to-back ADDs, out_ready low for 3 cycles after the first result -> in_ready=0, first result held stable. No loss or duplication; 4 results in order; 1/cycle once out_ready=1.
- MUL with macro defined: A=7, B=6 -> in_ready low WIDTH cycles, res=42 at accept+WIDTH+1. Without macro: illegal=1, res=0 at accept+1.
